// File: rtl/iob_regfile_pkg.sv
// Shared constants and helpers for the iob_regfile flop-based register file.
package iob_regfile_pkg;

  // Widest word that col_sel can slice.
  localparam int unsigned COL_SEL_MAX_W = 256;

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic bit width_ok(input int unsigned data_width,
                                  input int unsigned num_col,
                                  input int unsigned col_width);
    return (data_width == num_col * col_width) && (data_width <= COL_SEL_MAX_W);
  endfunction

  // Column c of a word, right-aligned; callers cast down to their column width.
  function automatic logic [COL_SEL_MAX_W-1:0] col_sel(input logic [COL_SEL_MAX_W-1:0] word,
                                                       input int unsigned c,
                                                       input int unsigned col_width);
    logic [COL_SEL_MAX_W-1:0] mask;
    mask = (COL_SEL_MAX_W'(1) << col_width) - COL_SEL_MAX_W'(1);
    return (word >> (c * col_width)) & mask;
  endfunction

endpackage

// File: rtl/iob_regfile_col.sv
// One COL_WIDTH-wide column of the register file: DEPTH flops, sync clear, read mux.
// IOB_REG_FILE_RDATA_REG_EN selects a registered, write-first read port.
module iob_regfile_col
  import iob_regfile_pkg::*;
#(
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [COL_WIDTH-1:0]  wdata,
  output logic [COL_WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  logic [COL_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

`ifdef IOB_REG_FILE_RDATA_REG_EN
  // Write-first: a write to the addressed word is visible in the same registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (we) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
`else
  always_comb begin
    rdata = mem[addr];
  end
`endif

endmodule

// File: rtl/iob_regfile.sv
// Flop-based register file with per-column write enables and a shared address.
// Define IOB_REG_FILE_RDATA_REG_EN for a one-cycle registered read; default is combinational.
module iob_regfile
  import iob_regfile_pkg::*;
#(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [NUM_COL-1:0]    en,
  output logic [DATA_WIDTH-1:0] rdata
);

  if (!width_ok(DATA_WIDTH, NUM_COL, COL_WIDTH)) begin : g_width_check
    $error("iob_regfile: DATA_WIDTH must equal NUM_COL*COL_WIDTH (and fit col_sel)");
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [COL_WIDTH-1:0] col_wdata;

    always_comb begin
      col_wdata = COL_WIDTH'(col_sel(COL_SEL_MAX_W'(wdata), c, COL_WIDTH));
    end

    iob_regfile_col #(
      .COL_WIDTH  (COL_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_col (
      .clk   (clk),
      .rst   (rst),
      .we    (en[c]),
      .addr  (addr),
      .wdata (col_wdata),
      .rdata (rdata[c*COL_WIDTH +: COL_WIDTH])
    );
  end

endmodule

// File: tb/tb_iob_regfile.sv
// Self-checking bench for iob_regfile (NUM_COL=2, COL_WIDTH=4, ADDR_WIDTH=4, DATA_WIDTH=8).
module tb_iob_regfile;

  localparam int unsigned NC = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] addr = '0;
  logic [NC-1:0] en = '0;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  // Reference: array of words plus the value a registered read port would hold.
  logic [DW-1:0] model [NW];
  logic [DW-1:0] reg_rd = '0;

  iob_regfile #(
    .NUM_COL    (NC),
    .COL_WIDTH  (CW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wdata (wdata),
    .addr  (addr),
    .en    (en),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane_mask(input logic [NC-1:0] e);
    logic [DW-1:0] m;
    m = '0;
    for (int c = 0; c < NC; c++) begin
      if (e[c]) m = m | (DW'(8'h0F) << (c * CW));
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] expected();
`ifdef IOB_REG_FILE_RDATA_REG_EN
    return reg_rd;
`else
    return model[addr];
`endif
  endfunction

  task automatic step(input logic r, input logic [NC-1:0] e, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    rst = r; en = e; addr = a; wdata = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NW; i++) model[i] = '0;
      reg_rd = '0;
    end else begin
      model[a] = (model[a] & ~lane_mask(e)) | (d & lane_mask(e));
      reg_rd = model[a];
    end
    #1;
    rst = 1'b0; en = '0;
  endtask

  // Point at an address with no write; registered builds need an edge to see it.
  task automatic look(input logic [AW-1:0] a);
`ifdef IOB_REG_FILE_RDATA_REG_EN
    step(1'b0, '0, a, $urandom());
`else
    addr = a;
    en = '0;
    #1;
`endif
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0, '0);
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: rdata=%h expected=00", rdata);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < NW; i++) begin
      step(1'b0, 2'b01, AW'(i), DW'(i));
      checks++;
      if (rdata !== DW'(i) || rdata !== model[i]) begin
        errors++;
        $display("FAIL fill[%0d]: rdata=%h expected=%h", i, rdata, DW'(i));
      end
    end
  endtask

  task automatic test_retain();
    for (int i = 0; i < NW; i++) begin
      look(AW'(i));
      checks++;
      if (rdata !== DW'(i)) begin
        errors++;
        $display("FAIL retain[%0d]: rdata=%h expected=%h", i, rdata, DW'(i));
      end
    end
  endtask

  task automatic test_reset_pulse();
    step(1'b1, '0, 4'd9, 8'h00);
    for (int i = 0; i < NW; i++) begin
      look(AW'(i));
      checks++;
      if (rdata !== 8'h00) begin
        errors++;
        $display("FAIL cleared[%0d]: rdata=%h expected=00", i, rdata);
      end
    end
  endtask

  task automatic test_col_mask();
    step(1'b0, 2'b11, 4'd3, 8'hA5);
    step(1'b0, 2'b10, 4'd3, 8'h3C);
    checks++;
    if (rdata !== 8'h35) begin
      errors++;
      $display("FAIL col_mask: rdata=%h expected=35", rdata);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 2'b11, 4'd5, 8'h5A);
    step(1'b1, 2'b11, 4'd5, 8'hFF);
    look(4'd5);
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_priority: rdata=%h expected=00", rdata);
    end
  endtask

  task automatic test_same_edge();
`ifndef IOB_REG_FILE_RDATA_REG_EN
    logic [DW-1:0] old_word;
    step(1'b0, 2'b11, 4'd12, 8'h1E);
    old_word = model[12];
    rst = 1'b0; addr = 4'd12; en = 2'b11; wdata = 8'hC7;
    #1;
    checks++;
    if (rdata !== old_word) begin
      errors++;
      $display("FAIL same_edge_before: rdata=%h expected=%h", rdata, old_word);
    end
    step(1'b0, 2'b11, 4'd12, 8'hC7);
    checks++;
    if (rdata !== 8'hC7) begin
      errors++;
      $display("FAIL same_edge_after: rdata=%h expected=c7", rdata);
    end
`endif
  endtask

  task automatic test_reg_latency();
`ifdef IOB_REG_FILE_RDATA_REG_EN
    step(1'b0, 2'b11, 4'd3, 8'h21);
    step(1'b0, 2'b11, 4'd7, 8'h77);
    checks++;
    if (rdata !== 8'h77) begin
      errors++;
      $display("FAIL reg_write_first: rdata=%h expected=77", rdata);
    end
    addr = 4'd3;
    #1;
    checks++;
    if (rdata !== 8'h77) begin
      errors++;
      $display("FAIL reg_hold: rdata=%h expected=77", rdata);
    end
    look(4'd3);
    checks++;
    if (rdata !== 8'h21) begin
      errors++;
      $display("FAIL reg_latency: rdata=%h expected=21", rdata);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 29) == 0), NC'($urandom()), AW'($urandom()), DW'($urandom()));
      checks++;
      if (rdata !== expected()) begin
        errors++;
        $display("FAIL random_wr[%0d]: rdata=%h expected=%h", n, rdata, expected());
      end
      look(AW'($urandom()));
      checks++;
      if (rdata !== model[addr]) begin
        errors++;
        $display("FAIL random_rd[%0d]: addr=%0d rdata=%h expected=%h", n, addr, rdata, model[addr]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) model[i] = 'x;
    #2;
    test_reset();
    test_fill();
    test_retain();
    test_reset_pulse();
    test_col_mask();
    test_reset_priority();
    test_same_edge();
    test_reg_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
